// File: rtl/gs_loader_defs.sv
// rtl/gs_loader_defs.sv - shared constants for the GS ROM loader
// FSM state encodings, header length, default pacing values and the
// saturating byte counter helper used by gs_rom_loader.
package gs_loader_defs;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR   = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_TAIL  = 3'd5;

  localparam int ADDR_BYTES      = 4;
  localparam int DEF_WR_GAP      = 4;
  localparam int DEF_TAIL_CYCLES = 16;

  // hdr_cnt value while the final address byte is being taken
  localparam logic [1:0] HDR_LAST = 2'(ADDR_BYTES - 1);

  function automatic logic [23:0] sat_inc24(input logic [23:0] v);
    return (v == 24'hFF_FFFF) ? v : v + 24'd1;
  endfunction

endpackage

// File: rtl/gs_loader_pacer.sv
// rtl/gs_loader_pacer.sv - loadable down-counter timing the GAP and TAIL phases
// Ports:
//   clk_sys, reset_n : clock, asynchronous active-low reset
//   load, load_val   : restart the countdown at load_val
//   done             : high during the last cycle of the countdown
module gs_loader_pacer (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       done
);

  logic [7:0] cnt;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 8'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  // A phase loaded with N lasts N cycles: done is raised while the count reads 1.
  assign done = (cnt <= 8'd1);

endmodule

// File: rtl/gs_rom_loader.sv
// rtl/gs_rom_loader.sv - framed byte stream to paced GS loader write strobes
// Ports:
//   clk_sys, reset_n           : clock, asynchronous active-low reset
//   in_start, in_end           : one-cycle frame delimiters
//   in_data, in_valid, in_ready: byte stream handshake
//   loader_act/a/d/wr          : loader bus towards the GS wrapper
//   busy, err, byte_cnt        : status (not IDLE, sticky short header, bytes written)
module gs_rom_loader
  import gs_loader_defs::*;
#(
  parameter int WR_GAP      = DEF_WR_GAP,
  parameter int TAIL_CYCLES = DEF_TAIL_CYCLES
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        in_start,
  input  logic        in_end,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        loader_act,
  output logic [31:0] loader_a,
  output logic [7:0]  loader_d,
  output logic        loader_wr,
  output logic        busy,
  output logic        err,
  output logic [23:0] byte_cnt
);

  logic [2:0] state;
  logic [2:0] state_nx;
  logic [1:0] hdr_cnt;
  logic       end_pend;
  logic       pace_load;
  logic [7:0] pace_val;
  logic       pace_done;

  gs_loader_pacer u_pacer (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .load     (pace_load),
    .load_val (pace_val),
    .done     (pace_done)
  );

  // All strobes decode straight from the state register so an asynchronous
  // reset removes them in the same cycle.
  assign busy       = (state != ST_IDLE);
  assign loader_act = busy;
  assign loader_wr  = (state == ST_WRITE);
  assign in_ready   = (state == ST_HDR) || (state == ST_DATA);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: state_nx = ST_IDLE;
      ST_HDR: begin
        if (in_end)                               state_nx = ST_IDLE;
        else if (in_valid && hdr_cnt == HDR_LAST) state_nx = ST_DATA;
      end
      ST_DATA: begin
        if (in_valid)    state_nx = ST_WRITE;
        else if (in_end) state_nx = ST_TAIL;
      end
      ST_WRITE: begin
        if (WR_GAP != 0)              state_nx = ST_GAP;
        else if (end_pend || in_end)  state_nx = ST_TAIL;
        else                          state_nx = ST_DATA;
      end
      ST_GAP: begin
        if (pace_done) state_nx = (end_pend || in_end) ? ST_TAIL : ST_DATA;
      end
      ST_TAIL: begin
        if (pace_done) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    // A new frame overrides everything, including a simultaneous in_end.
    if (in_start) state_nx = ST_HDR;
  end

  // The pacer is (re)loaded on entry to GAP or TAIL only.
  always_comb begin
    pace_load = ((state_nx == ST_GAP)  && (state != ST_GAP)) ||
                ((state_nx == ST_TAIL) && (state != ST_TAIL));
    pace_val  = (state_nx == ST_TAIL) ? 8'(TAIL_CYCLES) : 8'(WR_GAP);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      hdr_cnt  <= 2'd0;
      end_pend <= 1'b0;
      loader_a <= 32'd0;
      loader_d <= 8'd0;
      err      <= 1'b0;
      byte_cnt <= 24'd0;
    end else begin
      state <= state_nx;
      if (in_start) begin
        hdr_cnt  <= 2'd0;
        byte_cnt <= 24'd0;
        err      <= 1'b0;
        end_pend <= 1'b0;
      end else begin
        case (state)
          ST_HDR: begin
            if (in_end) begin
              err <= 1'b1;
            end else if (in_valid) begin
              loader_a <= {loader_a[23:0], in_data};
              hdr_cnt  <= hdr_cnt + 2'd1;
            end
          end
          ST_DATA: begin
            if (in_valid) begin
              loader_d <= in_data;
              end_pend <= in_end;
            end
          end
          ST_WRITE: begin
            loader_a <= loader_a + 32'd1;
            byte_cnt <= sat_inc24(byte_cnt);
            end_pend <= end_pend | in_end;
          end
          ST_GAP: end_pend <= end_pend | in_end;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gs_rom_loader.sv
// tb/tb_gs_rom_loader.sv - self-checking bench for gs_rom_loader
module tb_gs_rom_loader;

  localparam int WR_GAP      = 4;
  localparam int TAIL_CYCLES = 16;

  logic        clk_sys  = 1'b0;
  logic        reset_n  = 1'b0;
  logic        in_start = 1'b0;
  logic        in_end   = 1'b0;
  logic [7:0]  in_data  = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        loader_act;
  logic [31:0] loader_a;
  logic [7:0]  loader_d;
  logic        loader_wr;
  logic        busy;
  logic        err;
  logic [23:0] byte_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [31:0] obs_a[$];
  logic [7:0]  obs_d[$];
  int          obs_c[$];
  logic [7:0]  exp_d[$];
  int          act_falls = 0;
  int          fall_cyc = 0;
  int          end_cyc = 0;
  logic        act_prev = 1'b0;

  gs_rom_loader #(.WR_GAP(WR_GAP), .TAIL_CYCLES(TAIL_CYCLES)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .in_start   (in_start),
    .in_end     (in_end),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .loader_act (loader_act),
    .loader_a   (loader_a),
    .loader_d   (loader_d),
    .loader_wr  (loader_wr),
    .busy       (busy),
    .err        (err),
    .byte_cnt   (byte_cnt)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (loader_wr) begin
      obs_a.push_back(loader_a);
      obs_d.push_back(loader_d);
      obs_c.push_back(cyc);
    end
    if (act_prev && !loader_act) begin
      act_falls = act_falls + 1;
      fall_cyc  = cyc;
    end
    act_prev = loader_act;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_obs();
    obs_a.delete();
    obs_d.delete();
    obs_c.delete();
    exp_d.delete();
    act_falls = 0;
  endtask

  task automatic pulse_start();
    in_start = 1'b1;
    @(negedge clk_sys);
    in_start = 1'b0;
  endtask

  task automatic pulse_end();
    in_end  = 1'b1;
    end_cyc = cyc;
    @(negedge clk_sys);
    in_end  = 1'b0;
  endtask

  // Holds the byte until a rising edge sees in_ready; waits = low-ready cycles seen.
  task automatic send_byte(input logic [7:0] b, output int waits);
    bit ok;
    ok = 0;
    waits = 0;
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 100 && !ok; t++) begin
      if (in_ready) ok = 1;
      else waits++;
      @(negedge clk_sys);
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_hdr(input logic [31:0] addr);
    int w;
    for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8], w);
  endtask

  task automatic send_data(input int n, input int idle_max, input bit chk_burst);
    int w;
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      exp_d.push_back(b);
      if (i > 0) repeat ($urandom_range(0, idle_max)) @(negedge clk_sys);
      send_byte(b, w);
      if (chk_burst && i > 0) chk("ready_low_run", w, WR_GAP + 1);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 400) begin
      @(negedge clk_sys);
      t++;
    end
    if (busy) chk("idle_timeout", 32'd0, 32'd1);
    @(negedge clk_sys);
  endtask

  task automatic check_writes(input string tag, input logic [31:0] base);
    chk({tag, "_nwr"}, obs_a.size(), exp_d.size());
    for (int i = 0; i < exp_d.size() && i < obs_a.size(); i++) begin
      chk({tag, "_addr"}, obs_a[i], base + 32'(i));
      chk({tag, "_data"}, 32'(obs_d[i]), 32'(exp_d[i]));
    end
  endtask

  initial begin
    int w;
    int n;
    int dly;
    int exp_fall;
    logic [31:0] addr;
    logic [31:0] addr2;
    logic [7:0]  b0;
    logic [7:0]  b1;

    // Reset state
    repeat (3) @(negedge clk_sys);
    chk("rst_act",   32'(loader_act), 32'd0);
    chk("rst_wr",    32'(loader_wr),  32'd0);
    chk("rst_a",     loader_a,        32'd0);
    chk("rst_d",     32'(loader_d),   32'd0);
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_err",   32'(err),        32'd0);
    chk("rst_cnt",   32'(byte_cnt),   32'd0);
    chk("rst_ready", 32'(in_ready),   32'd0);
    reset_n = 1'b1;
    @(negedge clk_sys);

    // Header + single byte, end latched during the write
    clear_obs();
    pulse_start();
    send_hdr(32'h8000_1234);
    exp_d.push_back(8'h5A);
    send_byte(8'h5A, w);
    pulse_end();
    wait_idle();
    check_writes("single", 32'h8000_1234);
    chk("single_cnt", 32'(byte_cnt), 32'd1);
    chk("single_falls", act_falls, 32'd1);
    if (obs_c.size() > 0)
      chk("single_tail", fall_cyc - obs_c[0], 1 + WR_GAP + TAIL_CYCLES);

    // Burst with continuous in_valid
    clear_obs();
    addr = $urandom;
    pulse_start();
    send_hdr(addr);
    send_data(3, 0, 1'b1);
    pulse_end();
    wait_idle();
    check_writes("burst", addr);
    if (obs_c.size() == 3) begin
      chk("burst_w1", obs_c[1] - obs_c[0], WR_GAP + 2);
      chk("burst_w2", obs_c[2] - obs_c[0], 2 * (WR_GAP + 2));
    end

    // Short header
    clear_obs();
    pulse_start();
    send_byte(8'h12, w);
    send_byte(8'h34, w);
    pulse_end();
    chk("short_act", 32'(loader_act), 32'd0);
    chk("short_err", 32'(err), 32'd1);
    repeat (4) @(negedge clk_sys);
    chk("short_nwr", obs_a.size(), 32'd0);
    chk("short_err_sticky", 32'(err), 32'd1);
    pulse_start();
    chk("err_cleared", 32'(err), 32'd0);

    // Restart during GAP
    clear_obs();
    addr  = $urandom;
    addr2 = $urandom;
    b0    = 8'($urandom);
    b1    = 8'($urandom);
    pulse_start();
    send_hdr(addr);
    send_byte(b0, w);
    @(negedge clk_sys);
    pulse_start();
    send_hdr(addr2);
    send_byte(b1, w);
    pulse_end();
    wait_idle();
    chk("restart_nwr", obs_a.size(), 32'd2);
    if (obs_a.size() == 2) begin
      chk("restart_a0", obs_a[0], addr);
      chk("restart_d0", 32'(obs_d[0]), 32'(b0));
      chk("restart_a1", obs_a[1], addr2);
      chk("restart_d1", 32'(obs_d[1]), 32'(b1));
    end
    chk("restart_falls", act_falls, 32'd1);
    chk("restart_cnt", 32'(byte_cnt), 32'd1);

    // Address wrap
    clear_obs();
    pulse_start();
    send_hdr(32'hFFFF_FFFF);
    send_data(2, 2, 1'b0);
    pulse_end();
    wait_idle();
    check_writes("wrap", 32'hFFFF_FFFF);

    // Reset during WRITE
    clear_obs();
    pulse_start();
    send_hdr($urandom);
    send_byte(8'($urandom), w);
    chk("prerst_wr", 32'(loader_wr), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_wr",  32'(loader_wr),  32'd0);
    chk("rst_mid_act", 32'(loader_act), 32'd0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    clear_obs();
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'($urandom);
      @(negedge clk_sys);
    end
    in_valid = 1'b0;
    chk("post_rst_nwr",   obs_a.size(),     32'd0);
    chk("post_rst_busy",  32'(busy),        32'd0);
    chk("post_rst_ready", 32'(in_ready),    32'd0);
    chk("post_rst_cnt",   32'(byte_cnt),    32'd0);

    // Random frames: end lands in WRITE, GAP or DATA depending on the delay
    for (int f = 0; f < 8; f++) begin
      clear_obs();
      addr = $urandom;
      n    = $urandom_range(1, 6);
      dly  = $urandom_range(0, 8);
      pulse_start();
      send_hdr(addr);
      send_data(n, 3, 1'b0);
      repeat (dly) @(negedge clk_sys);
      pulse_end();
      wait_idle();
      check_writes("rand", addr);
      chk("rand_cnt", 32'(byte_cnt), n);
      chk("rand_err", 32'(err), 32'd0);
      chk("rand_falls", act_falls, 32'd1);
      if (obs_c.size() == n) begin
        exp_fall = obs_c[n-1] + 1 + WR_GAP;
        if (end_cyc + 1 > exp_fall) exp_fall = end_cyc + 1;
        chk("rand_tail", fall_cyc, exp_fall + TAIL_CYCLES);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
